button_event_decoder: RTL and testbench

- Converts a raw, bouncy pushbutton level into classified one-cycle control events: press, short click, long press and auto-repeat.
- Sits between the board pushbuttons and the cellular-automata control logic (step, run/pause, speed select).
- Uses sustained-level semantics, so hold duration can be measured.
- Contains its own 2-FF synchronizer, stable-count debouncer and hold-classification FSM.

---
 rtl/button_event_decoder.sv | 153 +++++++++++++++
 tb/tb_button_event_decoder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/button_event_decoder.sv
// button_event_decoder
//   Turns a raw, bouncy pushbutton level into debounced level plus classified
//   one-cycle events (press, short click, long press, auto-repeat).
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   btn_raw      raw asynchronous button level, 1 = pressed
//   btn_state    debounced, registered button level
//   press_pulse  one cycle on debounced rising edge
//   short_pulse  one cycle on release when hold was shorter than LONG_CYC
//   long_pulse   one cycle when hold reaches LONG_CYC
//   repeat_pulse one cycle every REPEAT_CYC while held after long_pulse
module button_event_decoder #(
    parameter int DEBOUNCE_CYC = 250000,
    parameter int LONG_CYC     = 100000000,
    parameter int REPEAT_CYC   = 20000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_state,
    output logic press_pulse,
    output logic short_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYC);
    localparam int HOLD_W = $clog2(LONG_CYC);
    localparam int REP_W  = $clog2(REPEAT_CYC);

    localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CYC - 1);
    localparam logic [REP_W-1:0]  REP_MAX  = REP_W'(REPEAT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE,
        HELD,
        LONG
    } state_t;

    logic              sync1;
    logic              sync2;
    logic [DB_W-1:0]   db_cnt;
    logic              mismatch;
    logic              flip;
    logic              rise;
    logic              fall;

    state_t            state;
    state_t            state_next;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_next;
    logic [REP_W-1:0]  rep_cnt;
    logic [REP_W-1:0]  rep_next;
    logic              press_next;
    logic              short_next;
    logic              long_next;
    logic              repeat_next;

    // The FSM reacts to the flip condition itself rather than to btn_state,
    // so every pulse is registered on the same edge that changes btn_state.
    always_comb begin
        mismatch = (sync2 != btn_state);
        flip     = mismatch && (db_cnt == DB_MAX);
        rise     = flip && !btn_state;
        fall     = flip && btn_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            btn_state <= 1'b0;
            db_cnt    <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            if (!mismatch) begin
                db_cnt <= '0;
            end else if (flip) begin
                btn_state <= sync2;
                db_cnt    <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            hold_cnt     <= '0;
            rep_cnt      <= '0;
            press_pulse  <= 1'b0;
            short_pulse  <= 1'b0;
            long_pulse   <= 1'b0;
            repeat_pulse <= 1'b0;
        end else begin
            state        <= state_next;
            hold_cnt     <= hold_next;
            rep_cnt      <= rep_next;
            press_pulse  <= press_next;
            short_pulse  <= short_next;
            long_pulse   <= long_next;
            repeat_pulse <= repeat_next;
        end
    end

    // Release is tested before the long/repeat thresholds so it wins ties.
    always_comb begin
        state_next  = state;
        hold_next   = '0;
        rep_next    = '0;
        press_next  = 1'b0;
        short_next  = 1'b0;
        long_next   = 1'b0;
        repeat_next = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    press_next = 1'b1;
                    state_next = HELD;
                end
            end
            HELD: begin
                if (fall) begin
                    short_next = 1'b1;
                    state_next = IDLE;
                end else if (hold_cnt == HOLD_MAX) begin
                    long_next  = 1'b1;
                    state_next = LONG;
                end else begin
                    hold_next = hold_cnt + 1'b1;
                end
            end
            LONG: begin
                if (fall) begin
                    state_next = IDLE;
                end else if (rep_cnt == REP_MAX) begin
                    repeat_next = 1'b1;
                end else begin
                    rep_next = rep_cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_button_event_decoder.sv
module tb_button_event_decoder;

    localparam int DEB = 4;
    localparam int LNG = 20;
    localparam int REP = 5;

    logic clk = 1'b0;
    logic rst;
    logic btn_raw;
    logic btn_state;
    logic press_pulse;
    logic short_pulse;
    logic long_pulse;
    logic repeat_pulse;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    button_event_decoder #(
        .DEBOUNCE_CYC(DEB),
        .LONG_CYC    (LNG),
        .REPEAT_CYC  (REP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .btn_state   (btn_state),
        .press_pulse (press_pulse),
        .short_pulse (short_pulse),
        .long_pulse  (long_pulse),
        .repeat_pulse(repeat_pulse)
    );

    // Reference model: raw level delayed two samples, debounced level flips
    // once the last DEB synchronized samples all disagree with it, and events
    // are classified from the age of the current press in cycles.
    bit m_s1, m_s2, m_state, m_active;
    bit m_press, m_short, m_long, m_rep;
    int m_cycle, m_press_at;
    bit hist[$];

    int t_press, t_short, t_long, t_rep;

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_state = 0; m_active = 0;
        m_press = 0; m_short = 0; m_long = 0; m_rep = 0;
        m_cycle = 0; m_press_at = 0;
        hist.delete();
    endtask

    task automatic model_edge(input bit raw);
        bit flip;
        bit fall;
        bit rise;
        int d;
        hist.push_back(m_s2);
        if (hist.size() > DEB) void'(hist.pop_front());
        flip = (hist.size() == DEB);
        foreach (hist[i]) if (hist[i] == m_state) flip = 0;
        m_cycle++;
        rise = flip && !m_state;
        fall = flip && m_state;
        d = m_cycle - m_press_at;
        m_press = rise;
        m_short = fall && m_active && (d <= LNG);
        m_long  = m_active && !fall && (d == LNG);
        m_rep   = m_active && !fall && (d > LNG) && ((d - LNG) % REP == 0);
        if (fall) m_active = 0;
        if (rise) begin
            m_active   = 1;
            m_press_at = m_cycle;
        end
        if (flip) m_state = !m_state;
        m_s2 = m_s1;
        m_s1 = raw;
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check_bit("btn_state", btn_state, m_state);
        check_bit("press_pulse", press_pulse, m_press);
        check_bit("short_pulse", short_pulse, m_short);
        check_bit("long_pulse", long_pulse, m_long);
        check_bit("repeat_pulse", repeat_pulse, m_rep);
        check_int("pulse_onehot",
                  int'(press_pulse) + int'(short_pulse) + int'(long_pulse) + int'(repeat_pulse) <= 1, 1);
    endtask

    // One clock: check outputs of the previous edge, drive inputs, take edge.
    task automatic cyc(input bit raw, input bit r);
        @(negedge clk);
        compare_all();
        t_press += int'(press_pulse);
        t_short += int'(short_pulse);
        t_long  += int'(long_pulse);
        t_rep   += int'(repeat_pulse);
        btn_raw = raw;
        if (r && !rst) begin
            rst = 1'b1;
            #1;
            model_reset();
            check_bit("rst_btn_state", btn_state, 1'b0);
            check_bit("rst_press", press_pulse, 1'b0);
            check_bit("rst_short", short_pulse, 1'b0);
            check_bit("rst_long", long_pulse, 1'b0);
            check_bit("rst_repeat", repeat_pulse, 1'b0);
        end else begin
            rst = r;
        end
        @(posedge clk);
        if (!rst) model_edge(raw);
    endtask

    task automatic hold(input bit raw, input int n);
        repeat (n) cyc(raw, 1'b0);
    endtask

    task automatic clear_tally();
        t_press = 0; t_short = 0; t_long = 0; t_rep = 0;
    endtask

    task automatic check_tally(input string tag, input int p, input int s, input int l, input int r);
        check_int({tag, "_press"}, t_press, p);
        check_int({tag, "_short"}, t_short, s);
        check_int({tag, "_long"}, t_long, l);
        check_int({tag, "_repeat"}, t_rep, r);
    endtask

    initial begin
        rst = 1'b1;
        btn_raw = 1'b0;
        model_reset();
        clear_tally();
        repeat (3) cyc(1'b0, 1'b1);
        hold(0, 4);

        // Clean press: btn_state high for 10 cycles.
        clear_tally();
        hold(1, 10);
        hold(0, 12);
        check_tally("clean", 1, 1, 0, 0);

        // Bounce of 2-cycle segments before a steady press.
        clear_tally();
        hold(1, 2); hold(0, 2); hold(1, 2); hold(0, 2);
        hold(1, 15);
        hold(0, 12);
        check_tally("bounce", 1, 1, 0, 0);

        // Long hold of 40 cycles: repeats at 25, 30, 35 only.
        clear_tally();
        hold(1, 40);
        hold(0, 12);
        check_tally("long40", 1, 0, 1, 3);

        // Release exactly at the long threshold.
        clear_tally();
        hold(1, 20);
        hold(0, 12);
        check_tally("thresh20", 1, 1, 0, 0);

        // One cycle past the threshold.
        clear_tally();
        hold(1, 21);
        hold(0, 12);
        check_tally("thresh21", 1, 0, 1, 0);

        // Short glitch while in long press keeps cadence.
        clear_tally();
        hold(1, 30); hold(0, 3); hold(1, 17);
        hold(0, 12);
        check_tally("glitch", 1, 0, 1, 5);

        // Reset while held in long press.
        hold(1, 30);
        clear_tally();
        repeat (3) cyc(1'b1, 1'b1);
        hold(1, 26);
        check_tally("rst_hold", 1, 0, 0, 0);
        hold(1, 1);
        check_int("rst_hold_long", t_long, 1);
        hold(0, 12);

        // Randomized levels and durations with occasional resets.
        for (int k = 0; k < 200; k++) begin
            bit lvl;
            int n;
            lvl = 1'($urandom_range(0, 1));
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(18, 60)) : int'($urandom_range(1, 8));
            if ($urandom_range(0, 24) == 0) begin
                repeat (2) cyc(lvl, 1'b1);
            end
            hold(lvl, n);
        end
        hold(0, 12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
